// File: rtl/multi_button_debouncer.sv
// -----------------------------------------------------------------------------
// multi_button_debouncer
// N-channel push-button conditioner. Each channel has a 2-flop synchroniser,
// a counter-based debounce filter, a debounced level, one-cycle press/release
// pulses and optional hold-to-repeat pulses.
//
// Ports:
//   i_Clk        slow tick clock
//   i_Rst_n      asynchronous active-low reset
//   i_Button     raw button inputs (asynchronous to i_Clk)
//   o_ButtonDeb  debounced level, same polarity as raw input
//   o_ButtonDown 1-cycle pulse on accepted press
//   o_ButtonUp   1-cycle pulse on accepted release
//   o_Repeat     1-cycle auto-repeat pulse while held (0 when repeat disabled)
//   o_AnyDown    OR of o_ButtonDown
// -----------------------------------------------------------------------------
module multi_button_debouncer #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned DEB_CYCLES    = 52,
    parameter int unsigned IDLE_LEVEL    = 1,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = 1000,
    parameter int unsigned REPEAT_PERIOD = 200
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [NUM_CH-1:0] i_Button,
    output logic [NUM_CH-1:0] o_ButtonDeb,
    output logic [NUM_CH-1:0] o_ButtonDown,
    output logic [NUM_CH-1:0] o_ButtonUp,
    output logic [NUM_CH-1:0] o_Repeat,
    output logic              o_AnyDown
);

    localparam int unsigned       CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic              IDLE_BIT = 1'(IDLE_LEVEL);
    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [NUM_CH-1:0]            sync1_q;
    logic [NUM_CH-1:0]            sync2_q;
    logic [NUM_CH-1:0]            stable_q,   stable_d;
    logic [NUM_CH-1:0]            down_q,     down_d;
    logic [NUM_CH-1:0]            up_q,       up_d;
    logic                         any_down_q, any_down_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q,      cnt_d;

    // Debounce filter: accept a new level after DEB_CYCLES consecutive
    // synchronised samples that differ from the current stable level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        down_d   = '0;
        up_d     = '0;
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            if (sync2_q[ch] == stable_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == DEB_LAST) begin
                stable_d[ch] = sync2_q[ch];
                cnt_d[ch]    = '0;
                if (sync2_q[ch] != IDLE_BIT) begin
                    down_d[ch] = 1'b1;
                end else begin
                    up_d[ch] = 1'b1;
                end
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
        any_down_d = |down_d;
    end

    // Synchroniser, filter state and registered pulses.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q    <= {NUM_CH{IDLE_BIT}};
            sync2_q    <= {NUM_CH{IDLE_BIT}};
            stable_q   <= {NUM_CH{IDLE_BIT}};
            cnt_q      <= '0;
            down_q     <= '0;
            up_q       <= '0;
            any_down_q <= 1'b0;
        end else begin
            sync1_q    <= i_Button;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            down_q     <= down_d;
            up_q       <= up_d;
            any_down_q <= any_down_d;
        end
    end

    assign o_ButtonDeb  = stable_q;
    assign o_ButtonDown = down_q;
    assign o_ButtonUp   = up_q;
    assign o_AnyDown    = any_down_q;

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam int unsigned RPT_MAX =
                (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int unsigned       RCNT_W      = $clog2(RPT_MAX + 1);
            localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
            localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

            typedef enum logic [1:0] {
                RPT_IDLE,
                RPT_WAIT_FIRST,
                RPT_REPEATING
            } rpt_state_e;

            for (genvar ch = 0; ch < int'(NUM_CH); ch++) begin : g_ch
                rpt_state_e        state_q,  state_d;
                logic [RCNT_W-1:0] rcnt_q,   rcnt_d;
                logic              repeat_q, repeat_d;

                // Repeat FSM keys off the acceptance events so the first
                // repeat lands exactly REPEAT_DELAY clocks after the press pulse.
                always_comb begin
                    state_d  = state_q;
                    rcnt_d   = rcnt_q;
                    repeat_d = 1'b0;
                    if (up_d[ch]) begin
                        state_d = RPT_IDLE;
                        rcnt_d  = '0;
                    end else if (down_d[ch]) begin
                        state_d = RPT_WAIT_FIRST;
                        rcnt_d  = '0;
                    end else begin
                        case (state_q)
                            RPT_WAIT_FIRST: begin
                                if (rcnt_q == DELAY_LAST) begin
                                    repeat_d = 1'b1;
                                    rcnt_d   = '0;
                                    state_d  = RPT_REPEATING;
                                end else begin
                                    rcnt_d = rcnt_q + RCNT_W'(1);
                                end
                            end
                            RPT_REPEATING: begin
                                if (rcnt_q == PERIOD_LAST) begin
                                    repeat_d = 1'b1;
                                    rcnt_d   = '0;
                                end else begin
                                    rcnt_d = rcnt_q + RCNT_W'(1);
                                end
                            end
                            default: begin
                                rcnt_d = '0;
                            end
                        endcase
                    end
                end

                always_ff @(posedge i_Clk or negedge i_Rst_n) begin
                    if (!i_Rst_n) begin
                        state_q  <= RPT_IDLE;
                        rcnt_q   <= '0;
                        repeat_q <= 1'b0;
                    end else begin
                        state_q  <= state_d;
                        rcnt_q   <= rcnt_d;
                        repeat_q <= repeat_d;
                    end
                end

                assign o_Repeat[ch] = repeat_q;
            end
        end else begin : g_no_repeat
            assign o_Repeat = '0;
        end
    endgenerate

endmodule
